md_unit: RTL

Execute-stage multiply/divide unit for the pipelined MIPS core. Takes the forwarded rs/rt operands that leave the E-stage forwarding selectors and runs `mult`/`multu`/`div`/`divu` over a fixed multi-cycle latency. It holds the architectural HI/LO registers and serves `mthi`/`mtlo`. It drives `busy` to the hazard controller, which stalls D while `busy | start` is high and the D instruction is HI/LO-class. HI/LO feed the E-stage result selection for `mfhi`/`mflo`.

---
 rtl/md_unit_pkg.sv | 28 ++
 rtl/md_core.sv | 65 ++++++
 rtl/md_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the execute-stage multiply/divide unit.
//   - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
//   - default latencies for multiply and divide
//   - FSM state type and the latency counter width
package md_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Wide enough for any sensible latency setting.
  localparam int CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // Divide-class opcodes share the upper encoding bit.
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_core.sv
// md_core: purely combinational multiply/divide arithmetic.
// Ports:
//   md_op    in  2   operation select (mult, multu, div, divu)
//   a        in  32  rs operand (multiplicand / dividend)
//   b        in  32  rt operand (multiplier / divisor)
//   result   out 64  {hi,lo}: product, or {remainder,quotient} for divides
//   div_zero out 1   divide-class op with a zero divisor
module md_core
  import md_unit_pkg::*;
(
  input  logic [1:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               signed_div;
  logic               a_neg;
  logic               b_neg;
  logic        [31:0] a_mag;
  logic        [31:0] b_mag;
  logic        [31:0] b_safe;
  logic        [31:0] q_mag;
  logic        [31:0] r_mag;
  logic        [31:0] quo;
  logic        [31:0] rem;

  always_comb begin
    // Multiply: extend both operands to 64 bits so the truncated 64-bit
    // product is exact for both signed and unsigned interpretations.
    a_sx   = {{32{a[31]}}, a};
    b_sx   = {{32{b[31]}}, b};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a} * {32'd0, b};

    // Divide on magnitudes, then restore signs. This makes
    // 0x80000000 / -1 fall out naturally: magnitude 0x80000000,
    // negated back to 0x80000000, remainder 0.
    signed_div = (md_op == MD_DIV);
    a_neg      = signed_div & a[31];
    b_neg      = signed_div & b[31];
    a_mag      = a_neg ? (32'd0 - a) : a;
    b_mag      = b_neg ? (32'd0 - b) : b;
    div_zero   = is_div_op(md_op) && (b == 32'd0);
    // Keep the divider well defined on a zero divisor; the result is
    // discarded at commit in that case.
    b_safe     = (b == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quo        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem        = a_neg ? (32'd0 - r_mag) : r_mag;

    case (md_op)
      MD_MULT:  result = $unsigned(prod_s);
      MD_MULTU: result = prod_u;
      default:  result = {rem, quo};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit holding architectural HI/LO.
// An operation is computed at launch, held in a pending register, and
// committed to HI/LO after a fixed latency so timing matches a multi-cycle
// unit.
// Ports:
//   clk    in  1   core clock, rising edge
//   reset  in  1   asynchronous active-low reset
//   start  in  1   one-cycle launch pulse (honoured in IDLE only)
//   md_op  in  2   00 mult, 01 multu, 10 div, 11 divu
//   mt_hi  in  1   write A into HI (IDLE, no start)
//   mt_lo  in  1   write A into LO (IDLE, no start)
//   A      in  32  forwarded rs value
//   B      in  32  forwarded rt value
//   busy   out 1   operation in flight (registered)
//   HI     out 32  architectural HI (registered)
//   LO     out 32  architectural LO (registered)
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        pend_q, pend_d;
  logic               pend_dz_q, pend_dz_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [63:0]        core_res;
  logic               core_dz;

  md_core u_core (
    .md_op    (md_op),
    .a        (A),
    .b        (B),
    .result   (core_res),
    .div_zero (core_dz)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_dz_d = pend_dz_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A launch takes priority over same-cycle move writes.
          pend_d    = core_res;
          pend_dz_d = core_dz;
          cnt_d     = is_div_op(md_op) ? DIV_CNT : MULT_CNT;
          busy_d    = 1'b1;
          state_d   = ST_RUN;
        end else begin
          if (mt_hi) hi_d = A;
          if (mt_lo) lo_d = A;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        // Counter reaches zero on this edge: commit and go idle.
        if (cnt_q == CNT_W'(1)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          if (!pend_dz_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_dz_q <= pend_dz_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
